exec_controller: RTL
====================

# exec_controller

Multi-cycle control unit of the mini serial processor. Fetches 16-bit instructions, decodes the register and immediate formats, reads operands from the 16×32 register bank and dispatches one packet at a time to the ALU, multiplier or barrel shifter over valid/ready handshakes. Executes LW/SW against data memory directly and writes results back to the bank. One instruction is in flight at any time; there is no pipelining.

## Interface
- `START_PC`, default 8'h00: PC value after reset.
- `clock`, in, 1: the single clock; every register samples on its rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `run`, in, 1: level input. 1 = execute; 0 = finish the current instruction, then idle.
- `busy`, out, 1: high in every state except IDLE.
- `pc`, out, 8: address of the current or next instruction.
- `retired`, out, 32: count of completed instructions; wraps at 2^32.
- `imem_addr`, out, 8; `imem_data`, in, 16: instruction ROM with 1-cycle synchronous read.
- `dmem_addr`, out, 8; `dmem_we`, out, 1; `dmem_wdata`, out, 32; `dmem_rdata`, in, 32: data RAM with 1-cycle synchronous read.
- `rf_rs1_addr`, out, 4; `rf_rs2_addr`, out, 4; `rf_rs1_data`, in, 32; `rf_rs2_data`, in, 32: combinational read ports.
- `rf_we`, out, 1; `rf_wd_addr`, out, 4; `rf_wd_data`, out, 32: register-bank write port.
- `alu_valid`, out, 1; `alu_ready`, in, 1; `alu_packet`, out, AluPacket.
- `alu_result_valid`, in, 1; `alu_result`, in, 32.
- `mul_valid`, out, 1; `mul_ready`, in, 1; `mul_packet`, out, MulPacket.
- `mul_result_valid`, in, 1; `mul_result`, in, 32 (low word of the product).
- `shf_valid`, out, 1; `shf_ready`, in, 1; `shf_packet`, out, ShifterPacket.
- `shf_result_valid`, in, 1; `shf_result`, in, 32.

## Operation
- **Unit routing:**
  - ADD, AND, OR go to the ALU.
  - MUL goes to the multiplier.
  - SHL, SHR go to the shifter.
  - LW and SW are handled by the controller's memory path.
- **Register format** (`is_immediate`=0): op_1 = reg[rs_1], op_2 = reg[rs_2], destination = rd.
- **Immediate format** (`is_immediate`=1) for unit operations: op_1 = reg[rd], op_2 = zero-extended `immediate`, destination = rd.
- **Shifter operands:** shift_amount = op_2[4:0]; op = op_1.
- **LW/SW:** always use the immediate format; the `is_immediate` bit is ignored.
  - LW: rd ← mem[immediate].
  - SW: mem[immediate] ← reg[rd].
- **No hardwired zero register:** all 16 registers are writable.
- **State machine:**
  - IDLE: when run=1, go to FETCH.
  - FETCH: drive imem_addr=pc, go to DECODE.
  - DECODE: latch imem_data into the instruction register and the register operands. Go to MEM for LW/SW, otherwise DISPATCH.
  - DISPATCH: assert the selected unit's valid with its packet held stable. On valid&ready, go to WAIT.
  - WAIT: on the selected unit's result_valid, latch the result and go to WB.
  - MEM (SW): dmem_we=1 for one cycle, then go to NEXT.
  - MEM (LW): drive dmem_addr, go to LOAD. LOAD: latch dmem_rdata, go to WB.
  - WB: rf_we=1 for exactly one cycle, then go to NEXT.
  - NEXT: pc ← pc+1 (0xFF wraps to 0x00), retired++. Go to FETCH if run=1, else IDLE.

## Timing
- **Reset values:**
  - pc = START_PC; retired = 0; state = IDLE.
  - All valid, we and busy outputs = 0.
  - All address and data outputs = 0.
- Reset acts asynchronously: outputs take their reset values immediately, including in the middle of DISPATCH or WAIT.
- A result_valid that arrives after reset, or from a unit that is not selected, is ignored.
- **Instruction latency, fetch to retire:**
  - Unit op: 6 cycles + (ready wait) + (result wait).
  - LW: 6 cycles.
  - SW: 4 cycles.
- **Handshake rules:**
  - valid stays high, and the packet bits stay frozen, until ready is sampled high.
  - valid drops in the cycle after acceptance.
  - At most one valid is high at any time.
- If result_valid is high in the same cycle as the accepting ready, the result is latched and the FSM goes straight to WB, skipping WAIT.
- run=0 mid-instruction does not abort: the instruction completes and retires, then the FSM enters IDLE.
- pc and retired update only in NEXT.

## Structure
- **Shared package additions:**
  - `ControllerState` enum (IDLE, FETCH, DECODE, DISPATCH, WAIT, MEM, LOAD, WB, NEXT).
  - `ExecUnit` enum (UNIT_ALU, UNIT_MUL, UNIT_SHF, UNIT_MEM).
  - `function ExecUnit unit_of(Operation)`.
- **Sub-module:** `instruction_decoder` (combinational). It takes an `Instruction` and outputs the unit, the register addresses and the immediate flag and value.
- **Top-level contents:** the FSM, PC, operand latches and handshake logic.

## Test plan
- **Reset:** assert reset_n=0 mid-WAIT of a MUL.
  - Required: mul_valid=0 immediately; pc=START_PC; busy=0.
  - A mul_result_valid pulse after reset is released causes no rf_we.
- **ADD, register format:** r1=5, r2=7, instruction 16'h0312.
  - Required: alu_packet = {op_2=7, op_1=5, ADD}; rf_we with r3=12; pc 0→1; retired=1.
- **OR, immediate format:** r4=0xF0, instruction 16'h540F.
  - Required: op_1=0xF0, op_2=0x0F; r4=0xFF.
- **MUL with back-pressure:** instruction 16'h6512, mul_ready low for 3 cycles.
  - Required: mul_packet stable throughout; after a 4-cycle result delay, r5=35.
- **SW then LW:** instruction 16'hF320 with r3=0xDEADBEEF.
  - Required: dmem_we for one cycle, addr 0x20, wdata 0xDEADBEEF.
  - Then instruction 16'hD620. Required: r6=0xDEADBEEF.
- **PC wrap and run drop:**
  - With pc=0xFF, retiring the instruction gives pc=0x00.
  - With run=0 during DISPATCH, the instruction completes and the FSM reaches IDLE with busy=0.

Source files
------------

// File: rtl/exec_controller_pkg.sv
// Shared types for the mini serial processor: instruction encoding, unit packets,
// controller states and the operation-to-unit routing.
package exec_controller_pkg;

    typedef enum logic [2:0] {
        OP_ADD, OP_AND, OP_OR, OP_MUL, OP_SHL, OP_SHR, OP_LW, OP_SW
    } Operation;

    // immediate = {rs_1, rs_2}
    typedef struct packed {
        Operation   op;
        logic       is_immediate;
        logic [3:0] rd;
        logic [3:0] rs_1;
        logic [3:0] rs_2;
    } Instruction;

    typedef struct packed {
        logic [31:0] op_2;
        logic [31:0] op_1;
        Operation    operation;
    } AluPacket;

    typedef struct packed {
        logic [31:0] op_2;
        logic [31:0] op_1;
    } MulPacket;

    typedef struct packed {
        logic [31:0] op;
        logic [4:0]  shift_amount;
        Operation    operation;
    } ShifterPacket;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, DISPATCH, WAIT, MEM, LOAD, WB, NEXT
    } ControllerState;

    typedef enum logic [1:0] {
        UNIT_ALU, UNIT_MUL, UNIT_SHF, UNIT_MEM
    } ExecUnit;

    function automatic ExecUnit unit_of(input Operation op);
        ExecUnit unit;
        case (op)
            OP_MUL:         unit = UNIT_MUL;
            OP_SHL, OP_SHR: unit = UNIT_SHF;
            OP_LW, OP_SW:   unit = UNIT_MEM;
            default:        unit = UNIT_ALU;
        endcase
        return unit;
    endfunction

endpackage

// File: rtl/exec_controller_decoder.sv
// Combinational instruction decoder: unit selection, register read addresses and
// the zero-extended immediate.
module instruction_decoder
    import exec_controller_pkg::*;
(
    input  Instruction  instr,
    output ExecUnit     unit,
    output logic [3:0]  rs1_addr,
    output logic [3:0]  rs2_addr,
    output logic [3:0]  rd_addr,
    output logic        use_imm,
    output logic [31:0] imm
);

    always_comb begin
        unit     = unit_of(instr.op);
        // Memory ops always take the immediate form regardless of is_immediate.
        use_imm  = instr.is_immediate || (unit == UNIT_MEM);
        rs1_addr = use_imm ? instr.rd : instr.rs_1;
        rs2_addr = instr.rs_2;
        rd_addr  = instr.rd;
        imm      = {24'd0, instr.rs_1, instr.rs_2};
    end

endmodule

// File: rtl/exec_controller.sv
// Multi-cycle controller: fetch, decode, dispatch to one execution unit over a
// valid/ready handshake (or run the memory path), write back, advance pc.
module exec_controller
    import exec_controller_pkg::*;
#(
    parameter logic [7:0] START_PC = 8'h00
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         run,
    output logic         busy,
    output logic [7:0]   pc,
    output logic [31:0]  retired,
    output logic [7:0]   imem_addr,
    input  logic [15:0]  imem_data,
    output logic [7:0]   dmem_addr,
    output logic         dmem_we,
    output logic [31:0]  dmem_wdata,
    input  logic [31:0]  dmem_rdata,
    output logic [3:0]   rf_rs1_addr,
    output logic [3:0]   rf_rs2_addr,
    input  logic [31:0]  rf_rs1_data,
    input  logic [31:0]  rf_rs2_data,
    output logic         rf_we,
    output logic [3:0]   rf_wd_addr,
    output logic [31:0]  rf_wd_data,
    output logic         alu_valid,
    input  logic         alu_ready,
    output AluPacket     alu_packet,
    input  logic         alu_result_valid,
    input  logic [31:0]  alu_result,
    output logic         mul_valid,
    input  logic         mul_ready,
    output MulPacket     mul_packet,
    input  logic         mul_result_valid,
    input  logic [31:0]  mul_result,
    output logic         shf_valid,
    input  logic         shf_ready,
    output ShifterPacket shf_packet,
    input  logic         shf_result_valid,
    input  logic [31:0]  shf_result
);

    ControllerState state, state_n;
    Instruction     fetched;
    ExecUnit        dec_unit, unit_q;
    logic [3:0]     dec_rs1, dec_rs2, dec_rd, rd_q;
    logic           dec_use_imm;
    logic [31:0]    dec_imm;
    Operation       op_q;
    logic [7:0]     mem_addr_q;
    logic [31:0]    op1_q, op2_q, result_q;
    logic           sel_ready, sel_rv, result_take;
    logic [31:0]    sel_result;

    assign fetched = imem_data;

    instruction_decoder u_decoder (
        .instr    (fetched),
        .unit     (dec_unit),
        .rs1_addr (dec_rs1),
        .rs2_addr (dec_rs2),
        .rd_addr  (dec_rd),
        .use_imm  (dec_use_imm),
        .imm      (dec_imm)
    );

    // Packets come straight from the operand latches, so they cannot move while valid waits.
    assign alu_packet = AluPacket'{op_2: op2_q, op_1: op1_q, operation: op_q};
    assign mul_packet = MulPacket'{op_2: op2_q, op_1: op1_q};
    assign shf_packet = ShifterPacket'{op: op1_q, shift_amount: op2_q[4:0], operation: op_q};
    assign busy       = (state != IDLE);

    always_comb begin
        sel_ready  = 1'b0;
        sel_rv     = 1'b0;
        sel_result = '0;
        case (unit_q)
            UNIT_ALU: begin sel_ready = alu_ready; sel_rv = alu_result_valid; sel_result = alu_result; end
            UNIT_MUL: begin sel_ready = mul_ready; sel_rv = mul_result_valid; sel_result = mul_result; end
            UNIT_SHF: begin sel_ready = shf_ready; sel_rv = shf_result_valid; sel_result = shf_result; end
            default:  ;
        endcase
    end

    always_comb begin
        state_n     = state;
        imem_addr   = '0;
        rf_rs1_addr = '0;
        rf_rs2_addr = '0;
        alu_valid   = 1'b0;
        mul_valid   = 1'b0;
        shf_valid   = 1'b0;
        dmem_addr   = '0;
        dmem_we     = 1'b0;
        dmem_wdata  = '0;
        rf_we       = 1'b0;
        rf_wd_addr  = '0;
        rf_wd_data  = '0;
        result_take = 1'b0;
        case (state)
            IDLE:   if (run) state_n = FETCH;
            FETCH: begin
                imem_addr = pc;
                state_n   = DECODE;
            end
            DECODE: begin
                rf_rs1_addr = dec_rs1;
                rf_rs2_addr = dec_rs2;
                state_n     = (dec_unit == UNIT_MEM) ? MEM : DISPATCH;
            end
            DISPATCH: begin
                alu_valid = (unit_q == UNIT_ALU);
                mul_valid = (unit_q == UNIT_MUL);
                shf_valid = (unit_q == UNIT_SHF);
                if (sel_ready) begin
                    // A result arriving with the accepting ready skips WAIT.
                    result_take = sel_rv;
                    state_n     = sel_rv ? WB : WAIT;
                end
            end
            WAIT: begin
                result_take = sel_rv;
                if (sel_rv) state_n = WB;
            end
            MEM: begin
                dmem_addr = mem_addr_q;
                if (op_q == OP_SW) begin
                    dmem_we    = 1'b1;
                    dmem_wdata = op1_q;
                    state_n    = NEXT;
                end else begin
                    state_n = LOAD;
                end
            end
            LOAD:   state_n = WB;
            WB: begin
                rf_we      = 1'b1;
                rf_wd_addr = rd_q;
                rf_wd_data = result_q;
                state_n    = NEXT;
            end
            NEXT:   state_n = run ? FETCH : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            pc         <= START_PC;
            retired    <= '0;
            unit_q     <= UNIT_ALU;
            op_q       <= OP_ADD;
            rd_q       <= '0;
            mem_addr_q <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            result_q   <= '0;
        end else begin
            state <= state_n;
            if (state == DECODE) begin
                unit_q     <= dec_unit;
                op_q       <= fetched.op;
                rd_q       <= dec_rd;
                mem_addr_q <= dec_imm[7:0];
                op1_q      <= rf_rs1_data;
                op2_q      <= dec_use_imm ? dec_imm : rf_rs2_data;
            end
            if (result_take)     result_q <= sel_result;
            if (state == LOAD)   result_q <= dmem_rdata;
            if (state == NEXT) begin
                pc      <= pc + 8'd1;
                retired <= retired + 32'd1;
            end
        end
    end

endmodule
